// File: rtl/prog_logic_fn_pkg.sv
// Shared types and limits for the programmable logic-function block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package prog_logic_fn_pkg;

    localparam int N_IN_MIN = 2;
    localparam int N_IN_MAX = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SWEEP = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Number of truth-table entries for an n-input function.
    function automatic int lut_depth(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/prog_logic_fn_if.sv
// Bundles the evaluate, configuration and sweep handshakes of prog_logic_fn.
// Latency: n/a (wiring only).
// Backpressure: in_ready / cfg_ready are driven by the block (slave side).
interface prog_logic_fn_if #(
    parameter int N_IN = 4
);
    logic            in_valid;
    logic [N_IN-1:0] in_vec;
    logic            in_ready;
    logic            f;
    logic            f_valid;
    logic            cfg_start;
    logic            cfg_valid;
    logic            cfg_bit;
    logic            cfg_ready;
    logic            sweep_start;
    logic            sweep_done;
    logic [N_IN:0]   sweep_ones;

    modport master (
        output in_valid, in_vec, cfg_start, cfg_valid, cfg_bit, sweep_start,
        input  in_ready, f, f_valid, cfg_ready, sweep_done, sweep_ones
    );

    modport slave (
        input  in_valid, in_vec, cfg_start, cfg_valid, cfg_bit, sweep_start,
        output in_ready, f, f_valid, cfg_ready, sweep_done, sweep_ones
    );
endinterface

// File: rtl/prog_logic_fn_lut_shift_reg.sv
// Serial shadow load of the truth table with a parallel commit to the active LUT.
// Latency: active LUT updates on the edge that accepts the last bit.
// Backpressure: none; the caller only asserts wr_i while the load is allowed.
module lut_shift_reg
    import prog_logic_fn_pkg::*;
#(
    parameter int                       N_IN     = 4,
    parameter logic [(1 << N_IN)-1:0]   LUT_INIT = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr_i,
    input  logic                      wr_i,
    input  logic                      bit_i,
    output logic [(1 << N_IN)-1:0]    lut_o,
    output logic                      commit_o
);
    localparam int            DEPTH = lut_depth(N_IN);
    localparam logic [N_IN:0] LAST  = (N_IN + 1)'(DEPTH - 1);

    logic [N_IN:0]    cnt_q, cnt_d;
    logic [DEPTH-1:0] shadow_q, shadow_d;
    logic [DEPTH-1:0] lut_q, lut_d;

    // Write the incoming bit at the counter index; commit includes that final bit.
    always_comb begin
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        commit_o = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
        end else if (wr_i) begin
            shadow_d[cnt_q[N_IN-1:0]] = bit_i;
            if (cnt_q == LAST) begin
                commit_o = 1'b1;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        lut_d = commit_o ? shadow_d : lut_q;
    end

    // Reset returns both copies to the power-up table and discards any partial load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            shadow_q <= LUT_INIT;
            lut_q    <= LUT_INIT;
        end else begin
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            lut_q    <= lut_d;
        end
    end

    assign lut_o = lut_q;

endmodule

// File: rtl/prog_logic_fn.sv
// Programmable N_IN-input logic function with serial truth-table load and self-sweep.
// Latency: f / f_valid one cycle after an accepted vector; sweep result 2**N_IN+1 cycles after start.
// Backpressure: in_ready only in IDLE with no start pulse; cfg_ready only in LOAD.
module prog_logic_fn
    import prog_logic_fn_pkg::*;
#(
    parameter int                       N_IN     = 4,
    parameter logic [(1 << N_IN)-1:0]   LUT_INIT = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    prog_logic_fn_if.slave  bus
);
    localparam int            DEPTH = lut_depth(N_IN);
    localparam logic [N_IN:0] LAST  = (N_IN + 1)'(DEPTH - 1);

    if (N_IN < N_IN_MIN || N_IN > N_IN_MAX) begin : g_bad_n_in
        $error("prog_logic_fn: N_IN outside supported range");
    end

    state_t           state_q;
    logic             f_q;
    logic             f_valid_q;
    logic             sweep_done_q;
    logic [N_IN:0]    sweep_cnt_q;
    logic [N_IN:0]    ones_q;
    logic [DEPTH-1:0] lut_w;
    logic             commit_w;
    logic             idle_w;
    logic             load_clr_w;
    logic             load_wr_w;

    assign idle_w     = (state_q == ST_IDLE);
    assign load_clr_w = idle_w & bus.cfg_start;
    assign load_wr_w  = (state_q == ST_LOAD) & bus.cfg_valid;

    lut_shift_reg #(
        .N_IN     (N_IN),
        .LUT_INIT (LUT_INIT)
    ) u_lut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (load_clr_w),
        .wr_i     (load_wr_w),
        .bit_i    (bus.cfg_bit),
        .lut_o    (lut_w),
        .commit_o (commit_w)
    );

    // Start pulses win over a vector in the same IDLE cycle, so withhold ready then.
    assign bus.in_ready  = idle_w & ~bus.cfg_start & ~bus.sweep_start;
    assign bus.cfg_ready = (state_q == ST_LOAD);

    // Control FSM with registered evaluate and sweep results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            f_q          <= 1'b0;
            f_valid_q    <= 1'b0;
            sweep_done_q <= 1'b0;
            sweep_cnt_q  <= '0;
            ones_q       <= '0;
        end else begin
            f_valid_q    <= 1'b0;
            sweep_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.cfg_start) begin
                        state_q <= ST_LOAD;
                    end else if (bus.sweep_start) begin
                        state_q     <= ST_SWEEP;
                        sweep_cnt_q <= '0;
                        ones_q      <= '0;
                    end else if (bus.in_valid) begin
                        f_q       <= lut_w[bus.in_vec];
                        f_valid_q <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (commit_w) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_SWEEP: begin
                    ones_q      <= ones_q + {{N_IN{1'b0}}, lut_w[sweep_cnt_q[N_IN-1:0]]};
                    sweep_cnt_q <= sweep_cnt_q + 1'b1;
                    if (sweep_cnt_q == LAST) begin
                        state_q      <= ST_DONE;
                        sweep_done_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.f          = f_q;
    assign bus.f_valid    = f_valid_q;
    assign bus.sweep_done = sweep_done_q;
    assign bus.sweep_ones = ones_q;

endmodule

// File: tb/tb_prog_logic_fn.sv
module tb_prog_logic_fn;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    prog_logic_fn_if #(.N_IN(4)) bus ();
    prog_logic_fn_if #(.N_IN(2)) bus2 ();

    prog_logic_fn #(.N_IN(4), .LUT_INIT(16'h0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    prog_logic_fn #(.N_IN(2), .LUT_INIT(4'b1000)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [15:0] model_lut;
    logic [3:0]  model_lut2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one vector in IDLE and compare the result against the reference table.
    task automatic send_vec(input logic [3:0] v);
        check($sformatf("in_ready_before_vec_%0h", v), 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_vec   = v;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check($sformatf("f_valid_vec_%0h", v), 32'(bus.f_valid), 32'd1);
        check($sformatf("f_vec_%0h", v), 32'(bus.f), 32'(model_lut[v]));
    endtask

    // Serial load, bit 0 first, with an optional stall of gap_len cycles before bit gap_at.
    task automatic load_lut(input logic [15:0] pat, input int gap_at, input int gap_len,
                            input logic [15:0] old);
        bus.cfg_start = 1'b1;
        @(negedge clk);
        bus.cfg_start = 1'b0;
        check("load_cfg_ready", 32'(bus.cfg_ready), 32'd1);
        check("load_in_ready", 32'(bus.in_ready), 32'd0);
        for (int i = 0; i < 16; i++) begin
            if (i == gap_at) begin
                bus.cfg_valid = 1'b0;
                for (int g = 0; g < gap_len; g++) begin
                    @(negedge clk);
                    check("stall_in_ready", 32'(bus.in_ready), 32'd0);
                    check("stall_lut_unchanged", 32'(dut.u_lut.lut_q), 32'(old));
                end
            end
            bus.cfg_valid = 1'b1;
            bus.cfg_bit   = pat[i];
            @(negedge clk);
            if (i < 15) begin
                check("mid_load_in_ready", 32'(bus.in_ready), 32'd0);
            end
        end
        bus.cfg_valid = 1'b0;
        check("post_load_in_ready", 32'(bus.in_ready), 32'd1);
        check("post_load_cfg_ready", 32'(bus.cfg_ready), 32'd0);
        check("post_load_lut", 32'(dut.u_lut.lut_q), 32'(pat));
        model_lut = pat;
    endtask

    // Sweep the main instance and compare cycle count and ones count with the model.
    task automatic run_sweep();
        int cyc;
        int exp_ones;
        exp_ones = $countones(model_lut);
        bus.sweep_start = 1'b1;
        @(negedge clk);
        bus.sweep_start = 1'b0;
        cyc = 0;
        while (!bus.sweep_done && cyc < 64) begin
            cyc++;
            @(negedge clk);
        end
        check("sweep_cycles", 32'(cyc), 32'd16);
        check("sweep_ones", 32'(bus.sweep_ones), 32'(exp_ones));
        @(negedge clk);
        check("sweep_done_pulse", 32'(bus.sweep_done), 32'd0);
        check("sweep_back_idle", 32'(bus.in_ready), 32'd1);
        check("sweep_ones_hold", 32'(bus.sweep_ones), 32'(exp_ones));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] r;
        logic [3:0]  vlist [6];
        int          cyc;
        int          seen;

        vlist = '{4'h0, 4'hC, 4'h6, 4'h9, 4'hF, 4'h3};

        rst_n            = 1'b0;
        bus.in_valid     = 1'b0;
        bus.in_vec       = '0;
        bus.cfg_start    = 1'b0;
        bus.cfg_valid    = 1'b0;
        bus.cfg_bit      = 1'b0;
        bus.sweep_start  = 1'b0;
        bus2.in_valid    = 1'b0;
        bus2.in_vec      = '0;
        bus2.cfg_start   = 1'b0;
        bus2.cfg_valid   = 1'b0;
        bus2.cfg_bit     = 1'b0;
        bus2.sweep_start = 1'b0;
        model_lut        = 16'h0000;
        model_lut2       = 4'b1000;

        repeat (3) @(negedge clk);
        check("rst_f", 32'(bus.f), 32'd0);
        check("rst_f_valid", 32'(bus.f_valid), 32'd0);
        check("rst_sweep_done", 32'(bus.sweep_done), 32'd0);
        check("rst_sweep_ones", 32'(bus.sweep_ones), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_cfg_ready", 32'(bus.cfg_ready), 32'd0);
        check("rst_lut", 32'(dut.u_lut.lut_q), 32'(model_lut));
        check("rst2_lut", 32'(dut2.u_lut.lut_q), 32'(model_lut2));

        rst_n = 1'b1;
        @(negedge clk);

        // Zero table after reset.
        send_vec(4'h0);
        send_vec(4'hF);
        @(negedge clk);
        check("f_valid_drops", 32'(bus.f_valid), 32'd0);

        // Directed pattern, then the listed vectors.
        load_lut(16'h9A58, -1, 0, 16'h0000);
        for (int i = 0; i < 6; i++) send_vec(vlist[i]);
        @(negedge clk);
        check("f_hold_valid", 32'(bus.f_valid), 32'd0);
        check("f_hold_value", 32'(bus.f), 32'(model_lut[vlist[5]]));

        // Random table with random vectors and a sweep.
        r = 16'($urandom);
        if (r == 16'h9A58) r = ~r;
        load_lut(r, -1, 0, 16'h9A58);
        for (int i = 0; i < 12; i++) send_vec(4'($urandom_range(0, 15)));
        run_sweep();

        // Stalled load must not disturb the active table before the commit.
        load_lut(16'h9A58, 8, 3, r);
        run_sweep();

        // Both starts together: load wins, vector not taken, later sweep_start ignored.
        bus.cfg_start   = 1'b1;
        bus.sweep_start = 1'b1;
        bus.in_valid    = 1'b1;
        bus.in_vec      = 4'hF;
        #1;
        check("prio_in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        bus.cfg_start   = 1'b0;
        bus.sweep_start = 1'b0;
        bus.in_valid    = 1'b0;
        check("prio_in_load", 32'(bus.cfg_ready), 32'd1);
        check("prio_no_vec", 32'(bus.f_valid), 32'd0);
        bus.sweep_start = 1'b1;
        @(negedge clk);
        bus.sweep_start = 1'b0;
        check("sweep_in_load_ignored", 32'(bus.cfg_ready), 32'd1);
        for (int i = 0; i < 16; i++) begin
            bus.cfg_valid = 1'b1;
            bus.cfg_bit   = 1'b1;
            @(negedge clk);
            check("no_done_in_load", 32'(bus.sweep_done), 32'd0);
        end
        bus.cfg_valid = 1'b0;
        model_lut = 16'hFFFF;
        check("ffff_back_idle", 32'(bus.in_ready), 32'd1);
        run_sweep();
        send_vec(4'($urandom_range(0, 15)));
        check("ones_hold_after_vec", 32'(bus.sweep_ones), 32'd16);

        // Small instance: N_IN=2 with a single set bit.
        bus2.sweep_start = 1'b1;
        @(negedge clk);
        bus2.sweep_start = 1'b0;
        cyc = 0;
        while (!bus2.sweep_done && cyc < 32) begin
            cyc++;
            @(negedge clk);
        end
        check("n2_sweep_cycles", 32'(cyc), 32'd4);
        check("n2_sweep_ones", 32'(bus2.sweep_ones), 32'($countones(model_lut2)));
        @(negedge clk);
        for (int v = 0; v < 4; v++) begin
            bus2.in_valid = 1'b1;
            bus2.in_vec   = 2'(v);
            @(negedge clk);
            bus2.in_valid = 1'b0;
            check($sformatf("n2_f_vec_%0d", v), 32'(bus2.f), 32'(model_lut2[v]));
        end

        // Reset halfway through a load returns the power-up table.
        bus.cfg_start = 1'b1;
        @(negedge clk);
        bus.cfg_start = 1'b0;
        r = 16'hA5C3;
        for (int i = 0; i < 8; i++) begin
            bus.cfg_valid = 1'b1;
            bus.cfg_bit   = r[i];
            @(negedge clk);
        end
        bus.cfg_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        model_lut = 16'h0000;
        check("abort_idle", 32'(bus.in_ready), 32'd1);
        check("abort_cfg_ready", 32'(bus.cfg_ready), 32'd0);
        check("abort_lut", 32'(dut.u_lut.lut_q), 32'(model_lut));
        check("abort_ones", 32'(bus.sweep_ones), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_not_load", 32'(bus.cfg_ready), 32'd0);
        send_vec(4'hF);
        send_vec(4'h0);

        // Reset mid-sweep: no done pulse afterwards.
        load_lut(16'h00FF, -1, 0, 16'h0000);
        bus.sweep_start = 1'b1;
        @(negedge clk);
        bus.sweep_start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.sweep_done) seen++;
        end
        check("no_done_after_sweep_reset", 32'(seen), 32'd0);
        check("sweep_reset_ones", 32'(bus.sweep_ones), 32'd0);
        model_lut = 16'h0000;
        run_sweep();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
